digdug_fgvram_arbiter: RTL and testbench

- Time-slot scheduler that shares the single-port foreground VRAM (1K x 8) between two requesters: the video scan-address generator and the CPU.
- Runs on the 48 MHz video master clock with a free-running 8-phase slot counter, matching the 6 MHz pixel period.
- Video owns one fixed read slot per period and is never stalled. The CPU gets one read/write slot per period through a four-phase REQ/ACK handshake.
- Sits between the CPU bus decode and the FG VRAM. It feeds the FG scanline generator the tile code on VID_DT.

---
 rtl/digdug_fgvram_arbiter_if.sv | 22 ++
 rtl/digdug_fgvram_arbiter.sv | 105 ++++++++++
 tb/tb_digdug_fgvram_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/digdug_fgvram_arbiter_if.sv
// ----------------------------------------------------------------------------
// digdug_fgvram_arbiter_if : CPU-side four-phase REQ/ACK bus to the FG VRAM arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface digdug_fgvram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] ad;
  logic [DW-1:0] di;
  logic          ack;
  logic [DW-1:0] rd;

  modport master (output req, we, ad, di, input ack, rd);
  modport slave  (input req, we, ad, di, output ack, rd);
endinterface

`default_nettype wire

// File: rtl/digdug_fgvram_arbiter.sv
// ----------------------------------------------------------------------------
// digdug_fgvram_arbiter : 8-phase time-slot sharing of the FG VRAM (video + CPU)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module digdug_fgvram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic                   clk48m,
  input  logic                   reset_n,
  digdug_fgvram_arbiter_if.slave cpu,
  input  logic [AW-1:0]          vid_ad,
  output logic [DW-1:0]          vid_dt,
  output logic [AW-1:0]          ram_ad,
  output logic                   ram_we,
  output logic [DW-1:0]          ram_di,
  input  logic [DW-1:0]          ram_do,
  output logic [2:0]             phase
);

  localparam logic [2:0] PH_VID_ISSUE = 3'd7;
  localparam logic [2:0] PH_VID_LATCH = 3'd1;
  localparam logic [2:0] PH_CPU_ISSUE = 3'd3;
  localparam logic [2:0] PH_CPU_RAM   = 3'd4;
  localparam logic [2:0] PH_CPU_CAPT  = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t        state;
  logic          is_write;
  logic          ack;
  logic [DW-1:0] cpu_rd;

  assign cpu.ack = ack;
  assign cpu.rd  = cpu_rd;

  always_ff @(posedge clk48m) begin
    if (!reset_n) begin
      phase    <= 3'd0;
      state    <= IDLE;
      is_write <= 1'b0;
      ack      <= 1'b0;
      cpu_rd   <= '0;
      vid_dt   <= '0;
      ram_ad   <= '0;
      ram_we   <= 1'b0;
      ram_di   <= '0;
    end else begin
      phase <= phase + 3'd1;

      // Video owns phase 0; its read data appears on ram_do during phase 1.
      if (phase == PH_VID_ISSUE) begin
        ram_ad <= vid_ad;
        ram_we <= 1'b0;
      end
      if (phase == PH_VID_LATCH) begin
        vid_dt <= ram_do;
      end

      case (state)
        IDLE: begin
          if (phase == PH_CPU_ISSUE && cpu.req) begin
            ram_ad   <= cpu.ad;
            ram_we   <= cpu.we;
            ram_di   <= cpu.di;
            is_write <= cpu.we;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (phase == PH_CPU_RAM) begin
            ram_we <= 1'b0;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (phase == PH_CPU_CAPT) begin
            if (!is_write) begin
              cpu_rd <= ram_do;
            end
            ack   <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!cpu.req) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_digdug_fgvram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_digdug_fgvram_arbiter : directed self-checking bench for the FG VRAM arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_digdug_fgvram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] vid_ad;
  logic [7:0] vid_dt;
  logic [9:0] ram_ad;
  logic       ram_we;
  logic [7:0] ram_di;
  logic [7:0] ram_do;
  logic [2:0] phase;

  always #5 clk = ~clk;

  digdug_fgvram_arbiter_if #(.AW(10), .DW(8)) cpu_bus ();

  digdug_fgvram_arbiter #(.AW(10), .DW(8)) dut (
    .clk48m  (clk),
    .reset_n (reset_n),
    .cpu     (cpu_bus),
    .vid_ad  (vid_ad),
    .vid_dt  (vid_dt),
    .ram_ad  (ram_ad),
    .ram_we  (ram_we),
    .ram_di  (ram_di),
    .ram_do  (ram_do),
    .phase   (phase)
  );

  // Synchronous 1K x 8 RAM with a side port for preloading
  logic [7:0] mem [1024];
  logic       pre_en = 1'b0;
  logic [9:0] pre_ad = '0;
  logic [7:0] pre_dt = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_ad] <= pre_dt;
    else if (ram_we) mem[ram_ad] <= ram_di;
    ram_do <= mem[ram_ad];
  end

  // Reference phase counter and invariant monitors
  logic [2:0] mphase = 3'd0;
  logic [2:0] last_ph = 3'd0;
  logic       ad_mon_en = 1'b0;
  int         we_bad = 0;
  int         ad_bad = 0;

  always @(posedge clk) begin
    last_ph   <= mphase;
    mphase    <= reset_n ? mphase + 3'd1 : 3'd0;
    ad_mon_en <= reset_n ? (ad_mon_en || mphase == 3'd7) : 1'b0;
  end

  always @(negedge clk) begin
    if (ram_we && (mphase != 3'd4 || !reset_n)) we_bad <= we_bad + 1;
    if (ad_mon_en && mphase == 3'd0 && ram_ad != vid_ad) ad_bad <= ad_bad + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next edge at which the phase was p
  task automatic to_edge(input logic [2:0] p);
    do step(); while (last_ph != p);
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pre_ad = a;
    pre_dt = d;
    pre_en = 1'b1;
    step();
    pre_en = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cpu_bus.ack && n < 64);
    if (!cpu_bus.ack) chk("ack_timeout", {31'd0, cpu_bus.ack}, 32'd1);
  endtask

  task automatic release_req(input string tag);
    cpu_bus.req = 1'b0;
    step();
    chk(tag, {31'd0, cpu_bus.ack}, 32'd0);
  endtask

  task automatic raise_req(input logic we, input logic [9:0] a, input logic [7:0] d);
    cpu_bus.we  = we;
    cpu_bus.ad  = a;
    cpu_bus.di  = d;
    cpu_bus.req = 1'b1;
  endtask

  initial begin
    int n;
    vid_ad = 10'h123;
    raise_req(1'b0, 10'h005, 8'h00);
    reset_n = 1'b0;

    // Reset held for at least 10 clocks with a request pending
    step();
    preload(10'h123, 8'h5A);
    preload(10'h124, 8'h77);
    preload(10'h125, 8'h99);
    preload(10'h005, 8'h11);
    preload(10'h200, 8'h3C);
    repeat (4) step();
    chk("rst_ack",    {31'd0, cpu_bus.ack}, 32'd0);
    chk("rst_phase",  {29'd0, phase}, 32'd0);
    chk("rst_vid_dt", {24'd0, vid_dt}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_ad", {22'd0, ram_ad}, 32'd0);
    chk("rst_ram_di", {24'd0, ram_di}, 32'd0);
    chk("rst_cpu_do", {24'd0, cpu_bus.rd}, 32'd0);

    reset_n = 1'b1;
    step();
    chk("phase_1", {29'd0, phase}, 32'd1);
    step();
    chk("phase_2", {29'd0, phase}, 32'd2);
    // ACK set at the 6th edge after release (edge where phase=5)
    wait_ack(n);
    chk("first_ack_edges", n + 2, 32'd6);
    chk("first_read_do", {24'd0, cpu_bus.rd}, 32'h11);
    release_req("first_ack_fall");

    // Video slot
    to_edge(3'd7);
    chk("vid_ram_ad_ph0", {22'd0, ram_ad}, 32'h123);
    to_edge(3'd1);
    chk("vid_dt_5a", {24'd0, vid_dt}, 32'h5A);
    vid_ad = 10'h124;
    n = 0;
    do begin step(); n++; end while (vid_dt == 8'h5A && n < 16);
    chk("vid_step1_period", n, 32'd8);
    chk("vid_dt_77", {24'd0, vid_dt}, 32'h77);
    vid_ad = 10'h125;
    n = 0;
    do begin step(); n++; end while (vid_dt == 8'h77 && n < 16);
    chk("vid_step2_period", n, 32'd8);
    chk("vid_dt_99", {24'd0, vid_dt}, 32'h99);

    // CPU write raised in phase 0
    to_edge(3'd7);
    raise_req(1'b1, 10'h3FF, 8'hC3);
    to_edge(3'd3);
    chk("wr_we_ph4", {31'd0, ram_we}, 32'd1);
    chk("wr_ad_ph4", {22'd0, ram_ad}, 32'h3FF);
    chk("wr_di_ph4", {24'd0, ram_di}, 32'hC3);
    chk("wr_ack_ph4", {31'd0, cpu_bus.ack}, 32'd0);
    step();
    chk("wr_we_ph5", {31'd0, ram_we}, 32'd0);
    chk("wr_ack_ph5", {31'd0, cpu_bus.ack}, 32'd0);
    step();
    chk("wr_ack_ph6", {31'd0, cpu_bus.ack}, 32'd1);
    release_req("wr_ack_fall");
    step();
    chk("wr_vid_ad_back", {22'd0, ram_ad}, 32'h125);
    chk("wr_di_hold", {24'd0, ram_di}, 32'hC3);

    // Read-after-write in the next period
    raise_req(1'b0, 10'h3FF, 8'h00);
    wait_ack(n);
    chk("raw_do", {24'd0, cpu_bus.rd}, 32'hC3);
    release_req("raw_ack_fall");

    // Worst case: request just misses a phase-3 edge; ACK-visible cycle ends 11 clocks later
    to_edge(3'd3);
    raise_req(1'b0, 10'h123, 8'h00);
    wait_ack(n);
    chk("worst_latency", n + 1, 32'd11);
    chk("worst_do", {24'd0, cpu_bus.rd}, 32'h5A);
    release_req("worst_ack_fall");

    // Best case: measured from the sampling edge
    to_edge(3'd2);
    raise_req(1'b0, 10'h124, 8'h00);
    to_edge(3'd3);
    wait_ack(n);
    chk("best_latency", n + 1, 32'd3);
    chk("best_do", {24'd0, cpu_bus.rd}, 32'h77);
    release_req("best_ack_fall");

    // Reset sampled at the same phase-3 edge that would accept a write
    to_edge(3'd2);
    raise_req(1'b1, 10'h200, 8'hE7);
    reset_n = 1'b0;
    step();
    chk("mid_rst_phase", {29'd0, phase}, 32'd0);
    repeat (3) step();
    chk("mid_rst_ack", {31'd0, cpu_bus.ack}, 32'd0);
    chk("mid_rst_we", {31'd0, ram_we}, 32'd0);
    cpu_bus.req = 1'b0;
    reset_n = 1'b1;
    step();
    step();
    raise_req(1'b0, 10'h200, 8'h00);
    wait_ack(n);
    chk("mid_rst_mem_kept", {24'd0, cpu_bus.rd}, 32'h3C);
    release_req("mid_rst_ack_fall");

    repeat (16) step();
    chk("we_outside_ph4", we_bad, 32'd0);
    chk("ram_ad_ph0_vid", ad_bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
